// File: rtl/fifo_serializer.sv
// Purpose : drains a FIFO one WL-bit word at a time and sends each word as a serial frame
//           (start bit low, WL data bits LSB first, [even parity], stop bit high).
// Latency : REQ and LOAD take one cycle each, then (WL+2)*BAUD_DIV line cycles per frame,
//           or (WL+3)*BAUD_DIV with parity. The next REQ comes one IDLE cycle after STOP.
// Backpressure: a new word is popped only when tx_en=1 and fifo_empty=0 in IDLE. A frame
//           that has started always runs to completion unless n_rst is asserted.
// Ports   : CLK, n_rst (async active-low), tx_en, fifo_empty, fifo_data[WL-1:0] ->
//           fifo_rd_rq (1-cycle pop pulse), ser_out (idles high), busy (REQ..STOP),
//           word_done (last cycle of STOP).
// Option  : define FIFO_SERIALIZER_PARITY_EN to insert an even-parity bit before STOP.
module fifo_serializer #(
    parameter int WL       = 5,
    parameter int BAUD_DIV = 4
) (
    input  logic          CLK,
    input  logic          n_rst,
    input  logic          tx_en,
    input  logic          fifo_empty,
    input  logic [WL-1:0] fifo_data,
    output logic          fifo_rd_rq,
    output logic          ser_out,
    output logic          busy,
    output logic          word_done
);

    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int CW = $clog2(WL + 1);

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(WL - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_STOP  = 3'd6;
`ifdef FIFO_SERIALIZER_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
    localparam logic [2:0] S_AFTER_DATA = S_PARITY;
`else
    localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

    logic [2:0]    state;
    logic [WL-1:0] shift_q;
    logic [BW-1:0] baud_cnt;
    logic [CW-1:0] bit_cnt;
    logic          baud_end;
`ifdef FIFO_SERIALIZER_PARITY_EN
    logic          par_q;
`endif

    assign baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge CLK or negedge n_rst) begin
        if (!n_rst) begin
            state    <= S_IDLE;
            shift_q  <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
`ifdef FIFO_SERIALIZER_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (tx_en && !fifo_empty) begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    // fifo_data is valid here, one cycle after the read request
                    shift_q  <= fifo_data;
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
`ifdef FIFO_SERIALIZER_PARITY_EN
                    par_q    <= ^fifo_data;
`endif
                    state    <= S_START;
                end
                S_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shift_q  <= shift_q >> 1;
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state <= S_AFTER_DATA;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef FIFO_SERIALIZER_PARITY_EN
                S_PARITY: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so reset forces them immediately.
    always_comb begin
        ser_out    = 1'b1;
        busy       = (state != S_IDLE);
        fifo_rd_rq = (state == S_REQ);
        word_done  = (state == S_STOP) && baud_end;
        case (state)
            S_START: ser_out = 1'b0;
            S_DATA:  ser_out = shift_q[0];
`ifdef FIFO_SERIALIZER_PARITY_EN
            S_PARITY: ser_out = par_q;
`endif
            default: ser_out = 1'b1;
        endcase
    end

endmodule

// File: doc/fifo_serializer.md
Name: fifo_serializer

Overview:
- Drain stage directly downstream of the FIFO memory block.
- Pops one WL-bit word at a time through the FIFO read request, using the empty flag to decide when to pop.
- Transmits each word as an asynchronous-style serial frame: start bit, data bits LSB first, stop bit.
- Gives the FIFO a real consumer so occupancy drains at a fixed, predictable rate.

Parameters:
- WL, 5, data word width; matches FIFO word width.
- BAUD_DIV, 4, clock cycles per serial bit period; legal range 1 and above.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- tx_en  input  1  transmit enable; gates starting new frames only.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  WL  FIFO data_out; valid the cycle after a read request.
- fifo_rd_rq  output  1  one-cycle read request pulse to FIFO.
- ser_out  output  1  serial line; idles high.
- busy  output  1  high from REQ through STOP inclusive.
- word_done  output  1  one-cycle pulse in the last cycle of STOP.

Behaviour:
- Reset: asynchronous on n_rst low. State=IDLE, ser_out=1, busy=0, fifo_rd_rq=0, word_done=0, shift register=0, counters=0. Takes effect immediately, including mid-frame; the partial frame is abandoned and the FIFO is not re-read for it.
- All outputs come from registered state or the shift register; no combinational path from inputs to outputs.
- FSM states: IDLE, REQ, LOAD, START, DATA, [PARITY], STOP.
- IDLE: ser_out=1, busy=0. Go to REQ when tx_en=1 and fifo_empty=0; otherwise stay.
- REQ: exactly one cycle; fifo_rd_rq=1. Always go to LOAD.
- LOAD: one cycle; shift register <= fifo_data; bit counter=0; baud counter=0. Go to START.
- START: ser_out=0 for BAUD_DIV cycles.
- DATA: ser_out=shift[0]; every BAUD_DIV cycles shift right by 1 and increment bit counter. After WL bit periods, go to STOP (or PARITY when enabled).
- STOP: ser_out=1 for BAUD_DIV cycles; word_done=1 on the final cycle. Then go to IDLE.
- Consecutive frames are separated by exactly one IDLE cycle, then REQ and LOAD. Inter-frame gap with ser_out high = IDLE+REQ+LOAD = 3 cycles, plus the stop period.
- Counter widths:
  - Baud counter: clog2(BAUD_DIV), minimum 1 bit; wraps at BAUD_DIV-1.
  - Bit counter: clog2(WL+1).
- tx_en low during a frame: the current frame completes normally; no new REQ is issued.
- fifo_empty changing after REQ: ignored for the current frame.
- fifo_rd_rq is never asserted while fifo_empty=1 (condition sampled in IDLE).
- Frame length, LOAD through end of STOP excluded: (WL+2)*BAUD_DIV cycles, or (WL+3)*BAUD_DIV with parity.

Optional Feature:
- Macro: FIFO_SERIALIZER_PARITY_EN.
- Defined: PARITY state inserted between DATA and STOP. ser_out = even parity (XOR of the WL data bits, latched at LOAD) for BAUD_DIV cycles.
- Undefined: no PARITY state; DATA goes directly to STOP. No parity logic is synthesized.

Test Plan (WL=5, BAUD_DIV=4):
1. Reset with n_rst=0 for 2 cycles, then release with fifo_empty=1, tx_en=1 -> ser_out=1, busy=0, fifo_rd_rq=0 indefinitely.
2. Single word: FIFO holds 22 (5'b10110), tx_en=1 -> fifo_rd_rq high exactly 1 cycle. ser_out holds 0 (start), then 0,1,1,0,1, then 1 (stop), each for 4 cycles. word_done pulses once; busy falls after STOP.
3. Back-to-back: FIFO holds 3 then 25 -> exactly two fifo_rd_rq pulses. Frames carry 1,1,0,0,0 then 1,0,0,1,1. One IDLE cycle separates the first STOP from the second REQ; fifo_empty=1 afterwards, so no third request.
4. Enable gating: tx_en=0 with FIFO non-empty for 20 cycles -> no fifo_rd_rq. Then tx_en=1, and tx_en=0 mid-DATA -> that frame completes fully and no further request is issued.
5. Reset mid-frame: n_rst pulsed low during the third data bit -> same cycle ser_out=1, busy=0. After release with FIFO holding 25 -> a fresh REQ and a complete frame for 25.
6. With FIFO_SERIALIZER_PARITY_EN defined, send word 22 (three ones) -> parity bit 1 held for 4 cycles before stop. Total START..STOP = 32 cycles.
